// File: rtl/merge_drain_pkg.sv
// rtl/merge_drain_pkg.sv - shared types for the merge drain block
package merge_drain_pkg;

    localparam int BANK_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [15:0] key;
        logic [15:0] value;
    } tuple_pair_t;

    // One bank read returns the even element and its odd neighbour together
    typedef struct packed {
        tuple_pair_t even;
        tuple_pair_t odd;
    } bank_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } drain_state_t;

endpackage

// File: rtl/merge_drain_pair_fifo.sv
// rtl/merge_drain_pair_fifo.sv - small synchronous FIFO of bank pairs
module pair_fifo
    import merge_drain_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  bank_pair_t push_data,
    input  logic       pop,
    output bank_pair_t head,
    output logic [AW:0] count,
    output logic       full,
    output logic       empty
);

    bank_pair_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Pointer/count update; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_drain.sv
// rtl/merge_drain.sv - unpacks the final sorted run from the bank pair into a stream
module merge_drain
    import merge_drain_pkg::*;
#(
    parameter int PAIR_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_in,
    input  int                         stream_len_in,
    input  logic                       pingpong_in,
    input  tuple_pair_t                even_data_in,
    input  tuple_pair_t                odd_data_in,
    output logic [BANK_ADDR_WIDTH-1:0] read_addr_out,
    output logic                       read_en_out,
    output logic                       bank_sel_out,
    output tuple_pair_t                data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       last_out,
    output logic                       busy_out,
    output logic                       done_out
);

    localparam int CW = $clog2(PAIR_DEPTH) + 1;

    drain_state_t state_q;
    int           len_q;
    int           rd_ptr_q;
    int           emit_cnt_q;
    logic         half_q;
    logic         inflight_q;
    logic         bank_sel_q;

    bank_pair_t   fifo_head;
    bank_pair_t   fifo_wdata;
    logic [CW-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         start_accept;
    logic         xfer;
    logic         is_last;
    logic         pop;
    int           occ_sum;

    assign start_accept = (state_q == ST_IDLE) && start_in;
    assign fifo_wdata   = '{even: even_data_in, odd: odd_data_in};

    pair_fifo #(.DEPTH(PAIR_DEPTH)) u_pair_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_accept),
        .push      (inflight_q),
        .push_data (fifo_wdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read issue counts the in-flight pair so the buffer can never overflow
    always_comb begin
        occ_sum     = int'(fifo_count) + int'(inflight_q);
        read_en_out = (state_q == ST_RUN) && (rd_ptr_q < len_q)
                      && (occ_sum < PAIR_DEPTH) && !fifo_full;
        valid_out   = (state_q == ST_RUN) && !fifo_empty;
        xfer        = valid_out && ready_in;
        is_last     = (emit_cnt_q == len_q - 1);
        // An odd-length run pops its final pair after the even half; the odd half is padding
        pop         = xfer && (half_q || is_last);
        last_out    = valid_out && is_last;
        data_out    = '0;
        if (valid_out) begin
            data_out = half_q ? fifo_head.odd : fifo_head.even;
        end
    end

    assign read_addr_out = rd_ptr_q[BANK_ADDR_WIDTH-1:0];
    assign bank_sel_out  = bank_sel_q;
    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = (state_q == ST_DONE);

    // Drain FSM with read pointer, half-select and emit counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= 0;
            rd_ptr_q   <= 0;
            emit_cnt_q <= 0;
            half_q     <= 1'b0;
            inflight_q <= 1'b0;
            bank_sel_q <= 1'b0;
        end else begin
            inflight_q <= read_en_out;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        len_q      <= stream_len_in;
                        bank_sel_q <= pingpong_in;
                        rd_ptr_q   <= 0;
                        emit_cnt_q <= 0;
                        half_q     <= 1'b0;
                        inflight_q <= 1'b0;
                        state_q    <= (stream_len_in == 0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (read_en_out) begin
                        rd_ptr_q <= rd_ptr_q + 2;
                    end
                    if (xfer) begin
                        emit_cnt_q <= emit_cnt_q + 1;
                        half_q     <= !pop;
                        if (is_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
